// File: rtl/spike_network_arbiter.sv
// Picks one spike per annealing step (round-robin over active neurons) and broadcasts {code,id}; latency active_neuron+1 cycles.
// Backpressure: scan starts only when all active neurons are in NETWORK; stays in WAIT until they all leave.
module spike_network_arbiter #(
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 512,
    parameter int NEURON_ID_WIDTH = 9
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_NEURON-1:0]                     en_network_vec,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_vec,
    input  logic [NEURON_ID_WIDTH-1:0]                active_neuron,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bcast,
    output logic                                      network_done,
    output logic                                      net_busy,
    output logic [NEURON_ID_WIDTH:0]                  fire_count
);

    localparam int IW = NEURON_ID_WIDTH;
    localparam int CW = NEURON_ID_WIDTH + 1;
    localparam int DW = TEN_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        act_q;
    logic [IW-1:0]        idx_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_fire_q;
    logic                 found_q;
    logic [DW-1:0]        win_code_q;
    logic [IW-1:0]        win_id_q;
    logic [DW+IW-1:0]     bcast_q;
    logic                 done_q;
    logic [CW-1:0]        fire_count_q;

    logic [NUM_NEURON-1:0] live_mask;
    logic [NUM_NEURON-1:0] held_mask;
    logic                  all_ready;
    logic                  any_held;

    logic [DW-1:0]        code;
    logic                 legal;
    logic                 take;
    logic                 found_d;
    logic [DW-1:0]        win_code_d;
    logic [IW-1:0]        win_id_d;
    logic [CW-1:0]        cnt_fire_d;
    logic [CW-1:0]        cnt_d;
    logic                 last_visit;
    logic [CW-1:0]        idx_inc;
    logic [IW-1:0]        idx_d;
    logic [CW-1:0]        win_inc;
    logic [IW-1:0]        rr_ptr_d;
    logic [IW-1:0]        scan_start;

    // Live count gates entry; the latched count governs the scan and the WAIT exit.
    always_comb begin
        live_mask = '0;
        held_mask = '0;
        for (int i = 0; i < NUM_NEURON; i++) begin
            live_mask[i] = (i < 32'(active_neuron));
            held_mask[i] = (i < 32'(act_q));
        end
    end

    assign all_ready = &(en_network_vec | ~live_mask);
    assign any_held  = |(en_network_vec & held_mask);

    assign code  = spike_vec[idx_q*DW +: DW];
    assign legal = (code == DW'(1)) || (code == DW'(2));
    assign take  = legal && !found_q;

    assign found_d    = found_q | legal;
    assign win_code_d = take ? code  : win_code_q;
    assign win_id_d   = take ? idx_q : win_id_q;
    assign cnt_fire_d = legal ? cnt_fire_q + 1'b1 : cnt_fire_q;

    assign cnt_d      = cnt_q + 1'b1;
    assign last_visit = (cnt_d == {1'b0, act_q});

    assign idx_inc = {1'b0, idx_q} + 1'b1;
    assign idx_d   = (idx_inc == {1'b0, act_q}) ? '0 : idx_inc[IW-1:0];

    assign win_inc  = {1'b0, win_id_q} + 1'b1;
    assign rr_ptr_d = (win_inc == {1'b0, act_q}) ? '0 : win_inc[IW-1:0];

    // A pointer left over from a larger array would never hit the wrap point.
    assign scan_start = (rr_ptr_q >= active_neuron) ? '0 : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            act_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            cnt_fire_q   <= '0;
            found_q      <= 1'b0;
            win_code_q   <= '0;
            win_id_q     <= '0;
            bcast_q      <= '0;
            done_q       <= 1'b0;
            fire_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (all_ready && (active_neuron != '0)) begin
                        state_q    <= SCAN;
                        act_q      <= active_neuron;
                        idx_q      <= scan_start;
                        cnt_q      <= '0;
                        cnt_fire_q <= '0;
                        found_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    idx_q      <= idx_d;
                    cnt_q      <= cnt_d;
                    cnt_fire_q <= cnt_fire_d;
                    found_q    <= found_d;
                    win_code_q <= win_code_d;
                    win_id_q   <= win_id_d;
                    // Outputs are loaded from the final visit's next-state so they are valid throughout DONE.
                    if (last_visit) begin
                        state_q      <= DONE;
                        done_q       <= 1'b1;
                        fire_count_q <= cnt_fire_d;
                        bcast_q      <= found_d ? {win_code_d, win_id_d} : '0;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= WAIT;
                    if (found_q) begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                WAIT: begin
                    if (!any_held) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spike_bcast  = bcast_q;
    assign network_done = done_q;
    assign net_busy     = (state_q != IDLE);
    assign fire_count   = fire_count_q;

endmodule
